traffic_quantizer: RTL



---
 rtl/traffic_quantizer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/traffic_quantizer.sv
// Per-lane queue counting and windowed 3-bit congestion quantization for one intersection.
// Optional macro QUANT_SLEW_LIMIT_EN limits each published level to dropping by 1 per publish.
module traffic_quantizer #(
   parameter int WINDOW      = 16,
   parameter int Q_WIDTH     = 8,
   parameter int LEVEL_SHIFT = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [3:0]  arrive,
   input  logic [3:0]  depart,
   output logic [11:0] traffic_out,
   output logic        traffic_valid,
   output logic [3:0]  overflow
);

   typedef enum logic [1:0] {IDLE, COUNT, PUBLISH} state_t;

   localparam logic [15:0]        WIN_LAST = 16'(WINDOW - 1);
   localparam logic [Q_WIDTH-1:0] Q_MAX    = '1;
   localparam logic [Q_WIDTH-1:0] LVL_MAX  = Q_WIDTH'(7);

   state_t      state_reg, state_next;
   logic [15:0] win_reg, win_next;
   logic [11:0] out_reg;
   logic        valid_reg;
   logic [11:0] pub_levels;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [Q_WIDTH-1:0] q_reg, q_next;
         logic [Q_WIDTH-1:0] shifted;
         logic               ovf_reg, ovf_hit;
         logic [2:0]         lvl, pub;

         always_comb begin
            q_next  = q_reg;
            ovf_hit = 1'b0;
            if (arrive[gi] && !depart[gi]) begin
               if (q_reg == Q_MAX) ovf_hit = 1'b1;
               else                q_next  = q_reg + 1'b1;
            end else if (!arrive[gi] && depart[gi] && q_reg != '0) begin
               q_next = q_reg - 1'b1;
            end
         end

         // Quantize the post-edge count so the last COUNT cycle's traffic is included.
         assign shifted = q_next >> LEVEL_SHIFT;
         assign lvl     = (shifted > LVL_MAX) ? 3'd7 : shifted[2:0];

`ifdef QUANT_SLEW_LIMIT_EN
         logic [2:0] prev_lvl, floor_lvl;
         always_comb begin
            prev_lvl  = out_reg[gi*3 +: 3];
            floor_lvl = (prev_lvl == 3'd0) ? 3'd0 : prev_lvl - 3'd1;
            pub       = (lvl < floor_lvl) ? floor_lvl : lvl;
         end
`else
         assign pub = lvl;
`endif

         always_ff @(posedge clk) begin
            if (rst) begin
               q_reg   <= '0;
               ovf_reg <= 1'b0;
            end else begin
               q_reg   <= q_next;
               ovf_reg <= ovf_reg | ovf_hit;
            end
         end

         assign pub_levels[gi*3 +: 3] = pub;
         assign overflow[gi]          = ovf_reg;
      end
   endgenerate

   always_comb begin
      state_next = state_reg;
      win_next   = win_reg;
      case (state_reg)
         IDLE: begin
            win_next = '0;
            if (en) state_next = COUNT;
         end
         COUNT: begin
            if (!en) begin
               state_next = IDLE;
               win_next   = '0;
            end else if (win_reg == WIN_LAST) begin
               state_next = PUBLISH;
               win_next   = '0;
            end else begin
               win_next = win_reg + 16'd1;
            end
         end
         PUBLISH: begin
            win_next   = '0;
            state_next = en ? COUNT : IDLE;
         end
         default: begin
            state_next = IDLE;
            win_next   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         win_reg   <= '0;
         out_reg   <= '0;
         valid_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         win_reg   <= win_next;
         valid_reg <= (state_next == PUBLISH);
         if (state_next == PUBLISH) out_reg <= pub_levels;
      end
   end

   assign traffic_out   = out_reg;
   assign traffic_valid = valid_reg;

endmodule
